// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if #(parameter int DSIZE = 32) ();
  logic             dmem_req;
  logic             dmem_we;
  logic [DSIZE-1:0] dmem_addr;
  logic [DSIZE-1:0] dmem_wdata;
  logic             dmem_ack;
  logic [DSIZE-1:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ack bus, stalls upstream while busy, registers MEM/WB.
// Optional access timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ASIZE = 5,
  parameter int DSIZE = 32,
  parameter int ISIZE = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 15
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ASIZE-1:0]    w_addr_in,
  input  logic [DSIZE-1:0]    w_data_in,
  input  logic [DSIZE-1:0]    Rdata2_in,
  input  logic                memWrite_in,
  input  logic                memRead_in,
  input  logic                memToReg_in,
  input  logic                wen_in,
  input  logic [ISIZE-1:0]    PC_in,
  output logic                stall_out,
  mem_access_stage_if.master  dmem,
  output logic [ASIZE-1:0]    w_addr_out,
  output logic [DSIZE-1:0]    w_data_out,
  output logic                wen_out,
  output logic [ISIZE-1:0]    PC_out,
  output logic                mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [DSIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [DSIZE-1:0] hold_q, hold_d;
  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [DSIZE-1:0] wres_q, wres_d;
  logic             wen_q, wen_d;
  logic [ISIZE-1:0] pc_q, pc_d;
  logic             mem_op;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign mem_op = memRead_in | memWrite_in;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    waddr_d   = waddr_q;
    wres_d    = wres_q;
    wen_d     = wen_q;
    pc_d      = pc_q;
    stall_out = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_out = 1'b1;
          addr_d    = w_data_in;
          wdata_d   = Rdata2_in;
          we_d      = memWrite_in;
          req_d     = 1'b1;
          hold_d    = '0;
          wen_d     = 1'b0;
          state_d   = BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          waddr_d = w_addr_in;
          wres_d  = w_data_in;
          wen_d   = wen_in;
          pc_d    = PC_in;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        wen_d     = 1'b0;
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          // Combined read+write bits count as a store: nothing to capture.
          if (!memWrite_in) hold_d = dmem.dmem_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q + 8'd1 == 8'(MEM_TIMEOUT)) begin
          req_d   = 1'b0;
          hold_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        waddr_d = w_addr_in;
        wres_d  = memToReg_in ? hold_q : w_data_in;
        wen_d   = wen_in;
        pc_d    = PC_in;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Stall must fall with reset even though the EXE/MEM inputs may still show a memory op.
    if (!rst) stall_out = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      waddr_q <= '0;
      wres_q  <= '0;
      wen_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      waddr_q <= waddr_d;
      wres_q  <= wres_d;
      wen_q   <= wen_d;
      pc_q    <= pc_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign w_addr_out      = waddr_q;
  assign w_data_out      = wres_q;
  assign wen_out         = wen_q;
  assign PC_out          = pc_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller that consumes the EXE/MEM pipeline register outputs, performs loads and stores on the data memory through a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and registers the MEM/WB pipeline outputs. It sits between the EXE/MEM register and the register-file write-back port. Non-memory instructions pass through in one cycle.

## Interface
- MEM_TIMEOUT, 15: maximum BUSY cycles without `dmem_ack` before abort. Used only with `MEM_TIMEOUT_EN`. Range 1..255; the counter is 8 bits.
- clk  in  1  clock; all flops sample on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- w_addr_in  in  `ASIZE`  destination register from EXE/MEM.
- w_data_in  in  `DSIZE`  ALU result. It is also the memory address for loads and stores.
- Rdata2_in  in  `DSIZE`  store data.
- memWrite_in, memRead_in, memToReg_in, wen_in  in  1 each  control bits from EXE/MEM.
- PC_in  in  `ISIZE`  instruction PC.
- stall_out  out  1  combinational. While high, the upstream stages hold; the EXE/MEM register keeps its contents.
- dmem_req  out  1  registered access request.
- dmem_we  out  1  registered; 1 = store.
- dmem_addr  out  `DSIZE`  registered address.
- dmem_wdata  out  `DSIZE`  registered store data.
- dmem_ack  in  1  memory completion, 1-cycle pulse.
- dmem_rdata  in  `DSIZE`  load data, valid while `dmem_ack` = 1.
- w_addr_out  out  `ASIZE`  registered MEM/WB destination.
- w_data_out  out  `DSIZE`  registered MEM/WB write data.
- wen_out  out  1  registered MEM/WB write enable.
- PC_out  out  `ISIZE`  registered MEM/WB PC.
- mem_err  out  1  sticky timeout flag. Tied to 0 without `MEM_TIMEOUT_EN`.

## Operation
- A memory op is `memRead_in | memWrite_in`.
- If both bits are set, the op is a store (`dmem_we` = 1) and no read data is captured.
- FSM states: IDLE, BUSY, DONE.
- **IDLE, no memory op:**
  - `stall_out` = 0.
  - MEM/WB registers load `w_addr_in`, `w_data_in`, `wen_in`, `PC_in`.
- **IDLE, memory op:**
  - `stall_out` = 1.
  - Load `dmem_addr` ← `w_data_in`, `dmem_wdata` ← `Rdata2_in`, `dmem_we` ← `memWrite_in`, `dmem_req` ← 1.
  - Clear the rdata hold register and the timeout counter.
  - Write a bubble into MEM/WB: `wen_out` ← 0.
  - Next state: BUSY.
- **BUSY:**
  - `stall_out` = 1. `wen_out` ← 0. `dmem_req`, `dmem_addr`, `dmem_wdata`, `dmem_we` stay stable.
  - On `dmem_ack`: `dmem_req` ← 0. For a read, hold ← `dmem_rdata`. Next state: DONE.
- **DONE:**
  - `stall_out` = 0.
  - MEM/WB registers load `w_addr_in`, `PC_in`, `wen_in`.
  - `w_data_out` ← `memToReg_in` ? hold : `w_data_in`. For a store with `memToReg_in` = 1, hold is 0.
  - Next state: IDLE.
- `dmem_ack` is ignored in IDLE and DONE.
- Upstream inputs are stable for the whole IDLE→BUSY→DONE sequence because `stall_out` holds them.
- Back-to-back memory ops: DONE→IDLE, then the next op issues in IDLE with no extra gap.

## Timing
- Reset (`rst` = 0) is asynchronous. It forces:
  - all outputs to 0;
  - state to IDLE;
  - hold register, timeout counter and `mem_err` to 0.
- Reset mid-BUSY aborts the access: `dmem_req` drops immediately and no MEM/WB write occurs.
- Non-memory op: 1-cycle latency to the MEM/WB outputs, no stall.
- Memory op: `dmem_req` rises on the edge that leaves IDLE. The earliest `dmem_ack` is in the first BUSY cycle.
- With the ack in BUSY cycle k (k ≥ 1), `stall_out` is high for k+1 cycles. The result appears on the MEM/WB outputs 2 edges after the ack edge.
- `stall_out` is a function of state and current inputs only; it has no dependency on `dmem_ack`.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - An 8-bit counter increments each BUSY cycle without `dmem_ack`.
  - When the counter reaches MEM_TIMEOUT: `dmem_req` ← 0, hold ← 0, `mem_err` ← 1 (sticky until reset), next state DONE.
  - The MEM/WB write proceeds normally with hold = 0.
  - If `dmem_ack` and the timeout occur in the same cycle, the ack wins and `mem_err` is unchanged.
- **`MEM_TIMEOUT_EN` undefined:**
  - No counter. BUSY waits indefinitely.
  - `mem_err` is constant 0.

## Test plan
- ALU op: `wen_in`=1, `w_addr_in`=5, `w_data_in`=0x1234 → next edge `wen_out`=1, `w_addr_out`=5, `w_data_out`=0x1234, `stall_out`=0 throughout.
- Load: `memRead_in`=1, `memToReg_in`=1, `w_data_in`=0x40, ack 3 cycles after `dmem_req` with rdata 0xBEEF → `dmem_addr`=0x40, `dmem_we`=0, `stall_out` high 4 cycles, then `w_data_out`=0xBEEF, `wen_out`=1.
- Store: `memWrite_in`=1, `Rdata2_in`=0xA5A5, `w_data_in`=0x10, ack on the first BUSY cycle → `dmem_we`=1, `dmem_wdata`=0xA5A5, `dmem_req` high 1 cycle, `wen_out`=0 after DONE.
- Back-to-back load then ALU op: no bubble beyond the stall cycles; the ALU result appears exactly 1 cycle after the load result.
- Assert `rst`=0 asynchronously mid-BUSY → `dmem_req`, `stall_out` and all outputs go to 0 before the next clock edge; the FSM is in IDLE after release.
- With `MEM_TIMEOUT_EN` and MEM_TIMEOUT=4, no ack → `dmem_req` drops after 4 BUSY cycles, `mem_err`=1, `w_data_out`=0 for the `memToReg_in`=1 load, and `mem_err` stays 1 through later ops.
